// File: rtl/systolic_pkg.sv
// Shared parameters and types for the systolic array and its result drain.
package systolic_pkg;
    localparam int NUM_ROW       = 8;
    localparam int NUM_COL       = 8;
    localparam int IN_WORD_SIZE  = 8;
    localparam int OUT_WORD_SIZE = 24;
    localparam int NUM_PE        = NUM_ROW * NUM_COL;

    typedef enum logic {IDLE, DRAIN} drain_state_e;
endpackage

// File: rtl/systolic_result_drain.sv
// Snapshots the systolic array accumulators on compute_done rising and streams
// them out row-major over valid/ready, so the array can restart while draining.
module systolic_result_drain
    import systolic_pkg::*;
#(
    parameter int NUM_ROW       = systolic_pkg::NUM_ROW,
    parameter int NUM_COL       = systolic_pkg::NUM_COL,
    parameter int OUT_WORD_SIZE = systolic_pkg::OUT_WORD_SIZE
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     compute_done,
    input  logic [0:OUT_WORD_SIZE*NUM_ROW*NUM_COL-1] pe_register_vals,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [OUT_WORD_SIZE-1:0]                 out_data,
    output logic [$clog2(NUM_ROW)-1:0]               out_row,
    output logic [$clog2(NUM_COL)-1:0]               out_col,
    output logic                                     out_last,
    output logic                                     busy,
    output logic                                     overrun
);
    localparam int N_PE = NUM_ROW * NUM_COL;
    localparam int SELW = $clog2(N_PE);
    localparam int IDXW = SELW + 1;
    localparam int ROWW = $clog2(NUM_ROW);
    localparam int COLW = $clog2(NUM_COL);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N_PE - 1);

    drain_state_e              r_state, w_state_nxt;
    logic                      r_done_q;
    logic [IDXW-1:0]           r_idx;
    logic                      r_overrun;
    logic [OUT_WORD_SIZE-1:0]  r_snap [N_PE];

    logic                      w_trig, w_drain, w_fire, w_at_last;
    logic [SELW-1:0]           w_sel;

    assign w_trig    = compute_done & ~r_done_q;
    assign w_drain   = (r_state == DRAIN);
    assign w_fire    = w_drain & out_ready;
    assign w_at_last = (r_idx == LAST_IDX);
    assign w_sel     = r_idx[SELW-1:0];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_trig) w_state_nxt = DRAIN;
            DRAIN:   if (w_fire && w_at_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // done_q resets high so a level already asserted out of reset is not an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_done_q  <= 1'b1;
            r_idx     <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_done_q <= compute_done;
            if (!w_drain && w_trig)
                r_idx <= '0;
            else if (w_fire)
                r_idx <= r_idx + IDXW'(1);
            if (w_drain && w_trig)
                r_overrun <= 1'b1;
        end
    end

    // Snapshot has no reset; its contents are only observed while draining
    always_ff @(posedge clk) begin
        if (!w_drain && w_trig) begin
            for (int k = 0; k < N_PE; k++)
                r_snap[k] <= pe_register_vals[k*OUT_WORD_SIZE +: OUT_WORD_SIZE];
        end
    end

    assign out_valid = w_drain;
    assign busy      = w_drain;
    assign out_last  = w_drain & w_at_last;
    assign overrun   = r_overrun;
    assign out_data  = w_drain ? r_snap[w_sel] : '0;
    assign out_row   = w_drain ? ROWW'(r_idx / IDXW'(NUM_COL)) : '0;
    assign out_col   = w_drain ? COLW'(r_idx % IDXW'(NUM_COL)) : '0;
endmodule

// File: tb/tb_systolic_result_drain.sv
// Self-checking bench for systolic_result_drain: vector table plus reset corner sequences.
module tb_systolic_result_drain;
    localparam int W   = 24;
    localparam int NPE = 64;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             compute_done = 1'b0;
    logic             out_ready = 1'b0;
    logic [0:W*NPE-1] pe_vals = '0;
    logic             out_valid, out_last, busy, overrun;
    logic [W-1:0]     out_data;
    logic [2:0]       out_row, out_col;

    systolic_result_drain dut (
        .clk(clk), .rst_n(rst_n), .compute_done(compute_done),
        .pe_register_vals(pe_vals), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_row(out_row), .out_col(out_col),
        .out_last(out_last), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        logic [2:0]   row;
        logic [2:0]   col;
        logic         last;
    } exp_t;

    typedef struct {
        int           ready_mode;
        bit           clobber;
        int           ovr_at;
        bit           hi63;
        logic [W-1:0] off;
        int           exp_cycles;
        bit           exp_ovr;
    } vec_t;

    exp_t q[$];
    vec_t vecs[6];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic load_pe(input logic [W-1:0] off, input bit hi63);
        for (int k = 0; k < NPE; k++) begin
            logic [W-1:0] v;
            v = W'(k + 1) + off;
            if (hi63 && k == NPE - 1) v = 24'h800001;
            pe_vals[k*W +: W] = v;
        end
    endtask

    // Called at a negedge with compute_done low through the previous edge.
    task automatic trigger();
        exp_t e;
        q.delete();
        for (int k = 0; k < NPE; k++) begin
            e.data = pe_vals[k*W +: W];
            e.row  = 3'(k / 8);
            e.col  = 3'(k % 8);
            e.last = (k == NPE - 1);
            q.push_back(e);
        end
        compute_done = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string name);
        chk(name, 64'({out_valid, out_data, out_row, out_col, out_last, busy, overrun}), 64'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        compute_done = 1'b0;
        out_ready = 1'b0;
        #1 chk_reset_outputs("reset_outputs");
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs until only `keep` words remain expected; words checked every valid cycle.
    task automatic drain(input int mode, input int ovr_at, input int keep,
                         input int budget, output int cycles);
        exp_t e;
        int   c;
        c = 0;
        while (q.size() > keep && c < budget) begin
            @(negedge clk);
            out_ready = (mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
            if (ovr_at >= 0 && c == ovr_at)     compute_done = 1'b0;
            if (ovr_at >= 0 && c == ovr_at + 1) compute_done = 1'b1;
            chk("valid_in_drain", 64'({out_valid, busy}), 64'(2'b11));
            if (out_valid) begin
                e = q[0];
                chk("word", 64'({out_data, out_row, out_col, out_last}),
                    64'({e.data, e.row, e.col, e.last}));
                if (out_ready) void'(q.pop_front());
            end
            c++;
        end
        cycles = c;
        if (q.size() > keep) begin
            failures++;
            $display("FAIL drain_timeout remaining=%0d required=%0d", q.size(), keep);
        end
    endtask

    initial begin
        int cyc;
        vecs[0] = '{0, 1'b0, -1, 1'b0, 24'h0,     64,  1'b0};
        vecs[1] = '{1, 1'b0, -1, 1'b0, 24'h0,     128, 1'b0};
        vecs[2] = '{0, 1'b1, -1, 1'b0, 24'h0,     64,  1'b0};
        vecs[3] = '{0, 1'b0,  5, 1'b0, 24'h0,     64,  1'b1};
        vecs[4] = '{0, 1'b0, -1, 1'b1, 24'h100,   64,  1'b0};
        vecs[5] = '{1, 1'b1, 20, 1'b0, 24'h7FFF00, 128, 1'b1};

        for (int i = 0; i < 6; i++) begin
            do_reset();
            load_pe(vecs[i].off, vecs[i].hi63);
            @(negedge clk);
            chk("idle_before_trigger", 64'({out_valid, busy}), 64'(0));
            trigger();
            if (vecs[i].clobber) begin
                @(posedge clk);
                #1 pe_vals = '1;
            end
            drain(vecs[i].ready_mode, vecs[i].ovr_at, 0, 300, cyc);
            chk("drain_cycles", 64'(cyc), 64'(vecs[i].exp_cycles));
            @(negedge clk);
            chk("idle_after_drain", 64'({out_valid, busy, out_last}), 64'(0));
            chk("overrun", 64'(overrun), 64'(vecs[i].exp_ovr));
            repeat (3) begin
                @(negedge clk);
                chk("no_second_drain", 64'(out_valid), 64'(0));
            end
        end

        // Reset mid-drain after 10 accepted words, with an overrun pending.
        do_reset();
        load_pe(24'h0, 1'b0);
        @(negedge clk);
        trigger();
        drain(0, 3, NPE - 10, 100, cyc);
        @(posedge clk);
        #1 chk("overrun_before_reset", 64'(overrun), 64'(1));
        rst_n = 1'b0;
        #1 chk_reset_outputs("reset_mid_drain");
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("no_capture_high_level", 64'({out_valid, busy}), 64'(0));
        end
        compute_done = 1'b0;
        @(negedge clk);
        chk("still_idle", 64'(out_valid), 64'(0));
        trigger();
        drain(0, -1, 0, 300, cyc);
        chk("redrain_cycles", 64'(cyc), 64'(64));
        @(negedge clk);
        chk("redrain_overrun", 64'({out_valid, overrun}), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end
endmodule
